// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan path.
package seg_pkg;

    localparam logic [7:0]  SEG_DARK       = 8'hFF;
    localparam int unsigned SEG_MAX_DIGITS = 8;

    // Decoder code for a visible hex digit.
    function automatic logic [7:0] seg_digit_code(input logic [3:0] nibble);
        return {4'h0, nibble};
    endfunction

endpackage

// File: rtl/seg_tick.sv
// Modulo-MOD counter with an enable; o_wrap_c flags the enabled cycle at MOD-1.
module seg_tick #(
    parameter int unsigned MOD = 8,
    localparam int unsigned W  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap_c
);

    logic [W-1:0] r_cnt;

    assign o_wrap_c = i_en && (r_cnt == W'(MOD - 1));
    assign o_cnt    = r_cnt;

    // Count on enable, returning to zero after MOD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap_c ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Multi-digit scan driver: shadow-buffered value, per-slot blanking,
// optional leading-zero suppression, registered decoder code and digit enables.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 1000,
    parameter int unsigned BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_en,
    output logic [7:0]            count,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  pending
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [PW-1:0]     w_pc;
    logic              w_pc_wrap;
    logic [IW-1:0]     w_idx;
    logic              w_frame_end;

    logic [VW-1:0]     r_shadow;
    logic [VW-1:0]     r_disp;
    logic              r_pending;
    logic [7:0]        r_count;
    logic [DIGITS-1:0] r_dig_n;

    logic [DIGITS-1:0] w_sup;
    logic [3:0]        w_nib;
    logic [7:0]        w_count_d;
    logic [DIGITS-1:0] w_dig_n_d;

    // Slot prescaler.
    seg_tick #(.MOD(DIV)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_en     (1'b1),
        .o_cnt    (w_pc),
        .o_wrap_c (w_pc_wrap)
    );

    // Digit index; its wrap coincides with the frame end.
    seg_tick #(.MOD(DIGITS)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_pc_wrap),
        .o_cnt    (w_idx),
        .o_wrap_c (w_frame_end)
    );

    // Shadow capture and frame-aligned transfer; a load on the frame end bypasses the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else if (load && w_frame_end) begin
            r_shadow  <= value;
            r_disp    <= value;
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadow  <= value;
            r_pending <= 1'b1;
        end else if (w_frame_end && r_pending) begin
            r_disp    <= r_shadow;
            r_pending <= 1'b0;
        end
    end

    // Next output code and enables for the current slot position.
    always_comb begin
        w_sup     = '0;
        w_nib     = 4'(r_disp >> {w_idx, 2'b00});
        w_count_d = SEG_DARK;
        w_dig_n_d = '1;
        for (int i = 1; i < int'(DIGITS); i++) begin
            w_sup[i] = lz_en && ((r_disp >> (4 * i)) == '0);
        end
        if (w_pc >= PW'(BLANK)) begin
            w_dig_n_d = ~(DIGITS'(1) << w_idx);
            w_count_d = w_sup[w_idx] ? SEG_DARK : seg_digit_code(w_nib);
        end
    end

    // Output registers, one cycle behind the scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= SEG_DARK;
            r_dig_n <= '1;
        end else begin
            r_count <= w_count_d;
            r_dig_n <= w_dig_n_d;
        end
    end

    assign count   = r_count;
    assign dig_n   = r_dig_n;
    assign pending = r_pending;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with DIGITS=4, DIV=8, BLANK=2.
module tb_seg_scan;

    localparam int D  = 4;
    localparam int DV = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        lz_en = 1'b0;
    logic [7:0]  count;
    logic [3:0]  dig_n;
    logic        pending;

    int checks   = 0;
    int failures = 0;

    // Reference state: m_t is the number of clock edges since reset release.
    int          m_t;
    logic [15:0] m_shadow, m_disp;
    logic        m_pending;
    logic [7:0]  exp_count;
    logic [3:0]  exp_dig_n;
    logic        exp_pending;

    seg_scan #(.DIGITS(D), .DIV(DV), .BLANK(BL)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .lz_en   (lz_en),
        .count   (count),
        .dig_n   (dig_n),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_t = 0;
        m_shadow = '0;
        m_disp = '0;
        m_pending = 1'b0;
    endtask

    // Advance one clock; expected outputs after the edge come from the scan position before it.
    task automatic step(input logic ld, input logic [15:0] v);
        int pc, idx;
        logic fe;
        logic [15:0] rest;
        load  = ld;
        value = v;
        pc  = m_t % DV;
        idx = (m_t / DV) % D;
        exp_count = 8'hFF;
        exp_dig_n = 4'hF;
        if (pc >= BL) begin
            exp_dig_n[idx] = 1'b0;
            rest = m_disp >> (4 * idx);
            if (lz_en && idx > 0 && rest == 16'h0) exp_count = 8'hFF;
            else exp_count = {4'h0, rest[3:0]};
        end
        fe = (pc == DV - 1) && (idx == D - 1);
        if (ld && fe) begin
            m_disp = v; m_shadow = v; m_pending = 1'b0;
        end else if (ld) begin
            m_shadow = v; m_pending = 1'b1;
        end else if (fe && m_pending) begin
            m_disp = m_shadow; m_pending = 1'b0;
        end
        exp_pending = m_pending;
        @(posedge clk);
        #1;
        load = 1'b0;
        m_t++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (count !== 8'hFF) begin failures++; $display("FAIL reset_count got=%h exp=ff", count); end
        checks++;
        if (dig_n !== 4'hF) begin failures++; $display("FAIL reset_dig_n got=%b exp=1111", dig_n); end
        checks++;
        if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            step(1'b0, 16'h0);
            checks++;
            if (count !== exp_count) begin failures++; $display("FAIL idle_count t=%0d got=%h exp=%h", m_t, count, exp_count); end
            checks++;
            if (dig_n !== exp_dig_n) begin failures++; $display("FAIL idle_dig_n t=%0d got=%b exp=%b", m_t, dig_n, exp_dig_n); end
            checks++;
            if ($countones(~dig_n) > 1) begin failures++; $display("FAIL idle_onehot t=%0d got=%b exp=at_most_one_low", m_t, dig_n); end
            if (m_t <= 2) begin
                checks++;
                if (count !== 8'hFF || dig_n !== 4'hF) begin failures++; $display("FAIL idle_dark t=%0d got=%h/%b exp=ff/1111", m_t, count, dig_n); end
            end else if (m_t <= 8) begin
                checks++;
                if (count !== 8'h00 || dig_n !== 4'b1110) begin failures++; $display("FAIL idle_digit0 t=%0d got=%h/%b exp=00/1110", m_t, count, dig_n); end
            end
        end
    endtask

    task automatic test_load();
        logic [7:0] codes [4];
        codes[0] = 8'h00; codes[1] = 8'h0F; codes[2] = 8'h03; codes[3] = 8'h0A;
        do_reset();
        lz_en = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step(m_t == 5, 16'hA3F0);
            checks++;
            if (count !== exp_count || dig_n !== exp_dig_n) begin failures++; $display("FAIL load_out t=%0d got=%h/%b exp=%h/%b", m_t, count, dig_n, exp_count, exp_dig_n); end
            checks++;
            if (pending !== exp_pending) begin failures++; $display("FAIL load_pending t=%0d got=%b exp=%b", m_t, pending, exp_pending); end
            if (m_t == 6 || m_t == 32) begin
                checks++;
                if (pending !== (m_t == 6)) begin failures++; $display("FAIL load_pending_edge t=%0d got=%b exp=%b", m_t, pending, m_t == 6); end
            end
            if (m_t == 20) begin
                checks++;
                if (count !== 8'h00) begin failures++; $display("FAIL load_old_frame t=%0d got=%h exp=00", m_t, count); end
            end
            for (int d = 0; d < D; d++) begin
                if (m_t == 36 + 8 * d) begin
                    checks++;
                    if (count !== codes[d] || dig_n[d] !== 1'b0) begin failures++; $display("FAIL load_digit%0d got=%h/%b exp=%h", d, count, dig_n, codes[d]); end
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [7:0] codes [4];
        codes[0] = 8'h00; codes[1] = 8'h05; codes[2] = 8'hFF; codes[3] = 8'hFF;
        do_reset();
        lz_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step(m_t == 3, 16'h0050);
            checks++;
            if (count !== exp_count || dig_n !== exp_dig_n) begin failures++; $display("FAIL lz_out t=%0d got=%h/%b exp=%h/%b", m_t, count, dig_n, exp_count, exp_dig_n); end
            for (int d = 0; d < D; d++) begin
                if (m_t == 36 + 8 * d) begin
                    checks++;
                    if (count !== codes[d] || dig_n[d] !== 1'b0) begin failures++; $display("FAIL lz_digit%0d got=%h/%b exp=%h", d, count, dig_n, codes[d]); end
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_bypass();
        logic [7:0] codes [4];
        codes[0] = 8'h04; codes[1] = 8'h03; codes[2] = 8'h02; codes[3] = 8'h01;
        do_reset();
        for (int k = 0; k < 64; k++) begin
            step(m_t == 31, 16'h1234);
            checks++;
            if (pending !== 1'b0) begin failures++; $display("FAIL bypass_pending t=%0d got=%b exp=0", m_t, pending); end
            checks++;
            if (count !== exp_count || dig_n !== exp_dig_n) begin failures++; $display("FAIL bypass_out t=%0d got=%h/%b exp=%h/%b", m_t, count, dig_n, exp_count, exp_dig_n); end
            for (int d = 0; d < D; d++) begin
                if (m_t == 36 + 8 * d) begin
                    checks++;
                    if (count !== codes[d]) begin failures++; $display("FAIL bypass_digit%0d got=%h exp=%h", d, count, codes[d]); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 64; k++) begin
            step(m_t == 5 || m_t == 10, (m_t == 5) ? 16'h1111 : 16'h2222);
            checks++;
            if (count !== exp_count || dig_n !== exp_dig_n || pending !== exp_pending) begin
                failures++; $display("FAIL b2b_out t=%0d got=%h/%b/%b exp=%h/%b/%b", m_t, count, dig_n, pending, exp_count, exp_dig_n, exp_pending);
            end
            for (int d = 0; d < D; d++) begin
                if (m_t == 36 + 8 * d) begin
                    checks++;
                    if (count !== 8'h02) begin failures++; $display("FAIL b2b_digit%0d got=%h exp=02", d, count); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 13; k++) step(m_t == 10, 16'hBEEF);
        checks++;
        if (pending !== exp_pending) begin failures++; $display("FAIL rstmid_pre_pending got=%b exp=%b", pending, exp_pending); end
        rst = 1'b1;
        #1;
        checks++;
        if (dig_n !== 4'hF || count !== 8'hFF || pending !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got=%b/%h/%b exp=1111/ff/0", dig_n, count, pending);
        end
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 16'h0);
            checks++;
            if (count !== exp_count || dig_n !== exp_dig_n || pending !== exp_pending) begin
                failures++; $display("FAIL rstmid_after t=%0d got=%h/%b/%b exp=%h/%b/%b", m_t, count, dig_n, pending, exp_count, exp_dig_n, exp_pending);
            end
            if (m_t == 4 || m_t == 28) begin
                checks++;
                if (count !== 8'h00) begin failures++; $display("FAIL rstmid_zero t=%0d got=%h exp=00", m_t, count); end
            end
        end
    endtask

    task automatic test_random();
        logic ld;
        logic [15:0] v;
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
            ld = ($urandom_range(0, 9) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            step(ld, v);
            checks++;
            if (count !== exp_count) begin failures++; $display("FAIL rand_count t=%0d got=%h exp=%h", m_t, count, exp_count); end
            checks++;
            if (dig_n !== exp_dig_n) begin failures++; $display("FAIL rand_dig_n t=%0d got=%b exp=%b", m_t, dig_n, exp_dig_n); end
            checks++;
            if (pending !== exp_pending) begin failures++; $display("FAIL rand_pending t=%0d got=%b exp=%b", m_t, pending, exp_pending); end
        end
        lz_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_lz();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multi-digit scan driver that sits directly upstream of the 7-segment decoder. It holds a multi-digit hexadecimal value and time-multiplexes it onto a single decoder, one digit per scan slot. Each scan step presents one digit's 8-bit `count` code to the decoder and drives the matching active-low common digit enable. Each slot starts with a blanking guard interval to prevent ghosting, and a shadow register ensures a new value never tears mid-frame.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `DIV`, 1000: clock cycles per digit slot; requires `DIV > BLANK`.
- `BLANK`, 16: blanking cycles at the start of each slot; legal range ≥1.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `value` into the shadow register.
- `value`  in  4*DIGITS  digits to show; nibble i is digit i, and digit 0 is least significant.
- `lz_en`  in  1  enables leading-zero suppression; sampled every cycle.
- `count`  out  8  code for the decoder: `{4'h0, nibble}` when showing a digit, `8'hFF` when dark.
- `dig_n`  out  DIGITS  active-low digit enables; at most one bit is low at any time.
- `pending`  out  1  a loaded value is waiting for the frame boundary.

## Operation
- State:
  - prescaler `pc`, range 0..DIV-1;
  - digit index `idx`, range 0..DIGITS-1;
  - `shadow` register;
  - `disp` register;
  - `pending` flag.
- `pc` increments every cycle and wraps from DIV-1 to 0.
- When `pc` wraps, `idx` increments, wrapping from DIGITS-1 to 0.
- Frame end is the cycle where `pc==DIV-1` and `idx==DIGITS-1`.
- Load behaviour:
  - `load=1` sets `shadow<=value` and `pending<=1`.
  - At frame end with `pending=1`: `disp<=shadow` and `pending<=0`.
  - `load` coinciding with frame end is a bypass: `disp<=value`, `shadow<=value`, `pending<=0`.
  - Back-to-back loads within a frame: the last one wins.
- Slot phase:
  - blank phase when `pc<BLANK`;
  - active phase otherwise.
- Blank phase: `dig_n` is all ones and `count=8'hFF`.
- Active phase:
  - `dig_n[idx]=0`, all other bits 1.
  - `count={4'h0, disp[4*idx+:4]}`.
  - Exception: when digit `idx` is suppressed, `count=8'hFF` while `dig_n[idx]` is still driven low (uniform duty cycle).
- Suppression: digit i is suppressed iff all of the following hold:
  - `lz_en=1`;
  - `i>0`;
  - `disp` nibbles i..DIGITS-1 are all zero.
- Digit 0 is never suppressed, so a value of 0 shows as a single "0".

## Timing
- Reset state (asynchronous, immediate):
  - `pc=0`, `idx=0`;
  - `shadow=0`, `disp=0`, `pending=0`;
  - `count=8'hFF`, `dig_n` all ones.
- `count` and `dig_n` are registered and lag `pc`/`idx` by exactly 1 cycle:
  - the output in cycle t+1 reflects the state in cycle t;
  - both outputs always change on the same edge.
- After reset release, the first active output appears at cycle BLANK+1 and shows digit 0.
- Each digit is enabled for DIV-BLANK cycles per frame. A frame is DIGITS*DIV cycles.
- `pending` is registered:
  - it goes high the cycle after `load`;
  - it goes low the cycle after the frame-end transfer.
- New `disp` content first appears at the first active cycle of digit 0 in the next frame, i.e. output cycle BLANK+1 after the transfer edge.
- `lz_en` changes take effect on the next output cycle, with no tearing protection.
- Reset mid-frame:
  - outputs go dark immediately;
  - `shadow`, `disp` and `pending` are cleared, so any pending load is lost.
- `DIGITS=1`: `idx` is constant 0, and every slot end is a frame end.

## Structure
- Shared package `seg_pkg`:
  - `SEG_DARK = 8'hFF`: the code the decoder treats as unlit.
  - `SEG_MAX_DIGITS = 8`.
  - A function `seg_digit_code(nibble)` returning `{4'h0, nibble}`.
- One natural sub-module, `seg_tick`:
  - parameterised modulo-DIV prescaler;
  - outputs `pc` and a `wrap` pulse;
  - reused for the digit counter.
- The top level holds the `idx` logic, the shadow/disp registers, suppression logic and the output registers.

## Test plan
Bench parameters: `DIGITS=4`, `DIV=8`, `BLANK=2`.

- Reset, then run 32 cycles with no load -> outputs dark on cycles 1-2; digit 0 active cycles 3-8 with `dig_n=4'b1110` and `count=8'h00`; digits 1-3 show `8'h00`; never more than one `dig_n` bit low.
- `load` with `value=16'hA3F0` at cycle 5 -> `pending=1` from cycle 6; first frame still shows 0000; next frame shows digit codes 00, 0F, 03, 0A in order; `pending=0` after the frame-end edge.
- `load 16'h0050` with `lz_en=1` -> digit 0 `count=00`, digit 1 `count=05`; digits 2 and 3 have `count=FF` with their `dig_n` bit still low.
- `load 16'h1234` exactly on a frame-end cycle -> bypass: `pending` never rises; the next frame shows 04, 03, 02, 01.
- Two loads in one frame, `16'h1111` then `16'h2222` -> the next frame shows only 02 on every digit.
- Assert `rst` mid-slot while a load is pending -> in the same cycle `dig_n=4'hF`, `count=FF`, `pending=0`; after release the display shows 0000.
